// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side frame handshake and host-side FIFO read port of uart_rx_ctrl.
// The master drives frames and pops; the slave (uart_rx_ctrl) presents the FIFO head.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATAWIDTH = 8
) ();
    logic [DATAWIDTH-1:0] rx_data;
    logic                 rx_done;
    logic                 p_err;
    logic                 frm_err;
    logic                 rx_busy;
    logic                 rd_en;
    logic                 rd_valid;
    logic [DATAWIDTH+1:0] rd_data;

    modport master (
        output rx_data,
        output rx_done,
        output p_err,
        output frm_err,
        output rx_busy,
        output rd_en,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rx_data,
        input  rx_done,
        input  p_err,
        input  frm_err,
        input  rx_busy,
        input  rd_en,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-path control: baud tick generation, frame-boundary parity config,
// show-ahead receive FIFO and sticky/saturating error status.
module uart_rx_ctrl #(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIVW       = 16,
    parameter int unsigned CNTW       = 8,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_enable,
    input  logic [DIVW-1:0]   baud_div,
    input  logic              cfg_par_en,
    input  logic              cfg_par_type,
    input  logic              cfg_load,
    output logic              par_en,
    output logic              par_type,
    output logic              bclk,
    uart_rx_ctrl_if.slave     rx,
    output logic [AW:0]       fifo_count,
    output logic              overflow,
    output logic [CNTW-1:0]   par_err_cnt,
    output logic [CNTW-1:0]   frm_err_cnt,
    input  logic              clr_status,
    output logic              cfg_pending
);

    typedef enum logic [1:0] {StOff, StRun, StHold} state_e;

    state_e            state_q, state_d;
    logic              par_en_q, par_en_d;
    logic              par_type_q, par_type_d;
    logic              hold_en_q, hold_en_d;
    logic              hold_type_q, hold_type_d;
    logic              pend_q, pend_d;
    logic [DIVW-1:0]   cnt_q, cnt_d;
    logic              bclk_q, bclk_d;
    logic              apply;
    logic              new_en, new_type;

    // Control FSM and config staging
    always_comb begin
        state_d     = state_q;
        par_en_d    = par_en_q;
        par_type_d  = par_type_q;
        hold_en_d   = hold_en_q;
        hold_type_d = hold_type_q;
        apply       = 1'b0;
        new_en      = cfg_par_en;
        new_type    = cfg_par_type;
        unique case (state_q)
            StOff: begin
                apply = cfg_load;
                if (rx_enable) state_d = StRun;
            end
            StRun: begin
                if (!rx_enable) begin
                    state_d = StOff;
                    apply   = cfg_load;
                end else if (cfg_load) begin
                    if (rx.rx_busy) begin
                        hold_en_d   = cfg_par_en;
                        hold_type_d = cfg_par_type;
                        state_d     = StHold;
                    end else begin
                        apply = 1'b1;
                    end
                end
            end
            StHold: begin
                // A load arriving while held replaces the staged values.
                new_en   = cfg_load ? cfg_par_en : hold_en_q;
                new_type = cfg_load ? cfg_par_type : hold_type_q;
                if (!rx_enable || !rx.rx_busy) begin
                    apply   = 1'b1;
                    state_d = rx_enable ? StRun : StOff;
                end else begin
                    hold_en_d   = new_en;
                    hold_type_d = new_type;
                end
            end
            default: state_d = StOff;
        endcase
        if (apply) begin
            par_en_d   = new_en;
            par_type_d = new_type;
        end
        pend_d = (state_d == StHold);
    end

    // Baud counter: wraps at baud_div, or immediately if already beyond a shrunk divisor.
    always_comb begin
        if (state_q == StOff || state_d == StOff || apply) begin
            cnt_d = '0;
        end else if (cnt_q >= baud_div) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIVW'(1);
        end
        bclk_d = (state_d != StOff) && (cnt_d == baud_div);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StOff;
            par_en_q    <= 1'b0;
            par_type_q  <= 1'b0;
            hold_en_q   <= 1'b0;
            hold_type_q <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            bclk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_en_q    <= par_en_d;
            par_type_q  <= par_type_d;
            hold_en_q   <= hold_en_d;
            hold_type_q <= hold_type_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            bclk_q      <= bclk_d;
        end
    end

    assign par_en      = par_en_q;
    assign par_type    = par_type_q;
    assign cfg_pending = pend_q;
    assign bclk        = bclk_q;

    // Receive FIFO
    logic [DATAWIDTH+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 push_req, push, pop, full, drop;
    logic [DATAWIDTH+1:0] entry;

    assign push_req = (state_q != StOff) && rx.rx_done;
    assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop      = rx.rd_en && (count_q != '0);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign entry    = {rx.frm_err, rx.p_err & par_en_q, rx.rx_data};

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign rx.rd_valid = (count_q != '0);
    assign rx.rd_data  = rx.rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;

    // Status: counting follows rx_done even when the frame is dropped.
    logic            par_inc, frm_inc, ovf_q, ovf_d;
    logic [CNTW-1:0] par_cnt_q, par_cnt_d, frm_cnt_q, frm_cnt_d;

    assign par_inc = push_req && rx.p_err && par_en_q;
    assign frm_inc = push_req && rx.frm_err;

    always_comb begin
        if (clr_status) begin
            par_cnt_d = par_inc ? CNTW'(1) : '0;
            frm_cnt_d = frm_inc ? CNTW'(1) : '0;
            ovf_d     = drop;
        end else begin
            par_cnt_d = par_cnt_q;
            frm_cnt_d = frm_cnt_q;
            if (par_inc && par_cnt_q != '1) par_cnt_d = par_cnt_q + CNTW'(1);
            if (frm_inc && frm_cnt_q != '1) frm_cnt_d = frm_cnt_q + CNTW'(1);
            ovf_d = ovf_q || drop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            par_cnt_q <= par_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign par_err_cnt = par_cnt_q;
    assign frm_err_cnt = frm_cnt_q;
    assign overflow    = ovf_q;

endmodule
